// File: rtl/mac_tx_scheduler.sv
// CAN MAC transmit scheduler: arbitrates LLC data/remote/overload requests,
// issues one frame at a time to the transmitter, retries failures and confirms.
module mac_tx_scheduler #(
  parameter int MAX_RETRIES = 3,
  parameter int RETRY_W     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [10:0] data_req_identifier,
  input  logic [3:0]  data_req_dlc,
  input  logic [63:0] data_req_data_payload,
  input  logic        remote_req_valid,
  output logic        remote_req_ready,
  input  logic [10:0] remote_req_identifier,
  input  logic [3:0]  remote_req_dlc,
  input  logic        ovld_req_valid,
  output logic        ovld_req_ready,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  tx_frame_type,
  output logic [10:0] tx_identifier,
  output logic [3:0]  tx_dlc,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  input  logic        tx_success,
  output logic        data_cnf_valid,
  input  logic        data_cnf_ready,
  output logic [10:0] data_cnf_identifier,
  output logic        data_cnf_status,
  output logic        remote_cnf_valid,
  input  logic        remote_cnf_ready,
  output logic [10:0] remote_cnf_identifier,
  output logic        remote_cnf_status,
  output logic        ovld_cnf_valid,
  input  logic        ovld_cnf_ready,
  output logic        ovld_cnf_status
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CONFIRM} state_t;
  typedef enum logic [1:0] {FT_DATA = 2'b00, FT_REMOTE = 2'b01, FT_OVLD = 2'b10} frame_t;

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t              state_q, state_d;
  frame_t              type_q, type_d;
  logic [10:0]         id_q, id_d;
  logic [3:0]          dlc_q, dlc_d;
  logic [63:0]         data_q, data_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                status_q, status_d;
  logic                grant_data, grant_remote, grant_ovld;
  logic                in_idle, cnf_ack;

  // Overload first; otherwise lowest identifier, data winning an identifier tie.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    grant_data   = 1'b0;
    grant_remote = 1'b0;
    grant_ovld   = 1'b0;
    if (ovld_req_valid) begin
      grant_ovld = 1'b1;
    end else if (data_req_valid && remote_req_valid) begin
      if (data_req_identifier <= remote_req_identifier) grant_data   = 1'b1;
      else                                               grant_remote = 1'b1;
    end else if (data_req_valid) begin
      grant_data = 1'b1;
    end else if (remote_req_valid) begin
      grant_remote = 1'b1;
    end
  end

  // reset_n gates the readies so none is offered while reset is held.
  assign in_idle          = reset_n && (state_q == IDLE);
  assign data_req_ready   = in_idle && grant_data;
  assign remote_req_ready = in_idle && grant_remote;
  assign ovld_req_ready   = in_idle && grant_ovld;

  always_comb begin
    cnf_ack = 1'b0;
    case (type_q)
      FT_DATA:   cnf_ack = data_cnf_ready;
      FT_REMOTE: cnf_ack = remote_cnf_ready;
      default:   cnf_ack = ovld_cnf_ready;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    id_d     = id_q;
    dlc_d    = dlc_q;
    data_d   = data_q;
    retry_d  = retry_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (grant_ovld) begin
          type_d  = FT_OVLD;
          id_d    = '0;
          dlc_d   = '0;
          data_d  = '0;
          retry_d = '0;
          state_d = ISSUE;
        end else if (grant_data) begin
          type_d  = FT_DATA;
          id_d    = data_req_identifier;
          dlc_d   = data_req_dlc;
          data_d  = data_req_data_payload;
          retry_d = '0;
          state_d = ISSUE;
        end else if (grant_remote) begin
          type_d  = FT_REMOTE;
          id_d    = remote_req_identifier;
          dlc_d   = remote_req_dlc;
          data_d  = '0;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (tx_success) begin
            status_d = 1'b0;
            state_d  = CONFIRM;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ISSUE;
          end else begin
            status_d = 1'b1;
            state_d  = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (cnf_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      type_q   <= FT_DATA;
      id_q     <= '0;
      dlc_q    <= '0;
      data_q   <= '0;
      retry_q  <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      id_q     <= id_d;
      dlc_q    <= dlc_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      status_q <= status_d;
    end
  end

  assign tx_valid              = (state_q == ISSUE);
  assign tx_frame_type         = type_q;
  assign tx_identifier         = id_q;
  assign tx_dlc                = dlc_q;
  assign tx_data               = data_q;
  assign data_cnf_valid        = (state_q == CONFIRM) && (type_q == FT_DATA);
  assign remote_cnf_valid      = (state_q == CONFIRM) && (type_q == FT_REMOTE);
  assign ovld_cnf_valid        = (state_q == CONFIRM) && (type_q == FT_OVLD);
  assign data_cnf_identifier   = id_q;
  assign data_cnf_status       = status_q;
  assign remote_cnf_identifier = id_q;
  assign remote_cnf_status     = status_q;
  assign ovld_cnf_status       = status_q;

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Self-checking bench for mac_tx_scheduler: directed scenarios plus randomized
// batches checked against a priority/retry reference model.
module tb_mac_tx_scheduler;

  localparam int MAXR = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        data_req_valid, data_req_ready;
  logic [10:0] data_req_identifier;
  logic [3:0]  data_req_dlc;
  logic [63:0] data_req_data_payload;
  logic        remote_req_valid, remote_req_ready;
  logic [10:0] remote_req_identifier;
  logic [3:0]  remote_req_dlc;
  logic        ovld_req_valid, ovld_req_ready;
  logic        tx_valid, tx_ready;
  logic [1:0]  tx_frame_type;
  logic [10:0] tx_identifier;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_done, tx_success;
  logic        data_cnf_valid, data_cnf_ready;
  logic [10:0] data_cnf_identifier;
  logic        data_cnf_status;
  logic        remote_cnf_valid, remote_cnf_ready;
  logic [10:0] remote_cnf_identifier;
  logic        remote_cnf_status;
  logic        ovld_cnf_valid, ovld_cnf_ready;
  logic        ovld_cnf_status;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mac_tx_scheduler #(.MAX_RETRIES(MAXR), .RETRY_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_identifier(data_req_identifier), .data_req_dlc(data_req_dlc),
    .data_req_data_payload(data_req_data_payload),
    .remote_req_valid(remote_req_valid), .remote_req_ready(remote_req_ready),
    .remote_req_identifier(remote_req_identifier), .remote_req_dlc(remote_req_dlc),
    .ovld_req_valid(ovld_req_valid), .ovld_req_ready(ovld_req_ready),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_frame_type(tx_frame_type),
    .tx_identifier(tx_identifier), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_done(tx_done), .tx_success(tx_success),
    .data_cnf_valid(data_cnf_valid), .data_cnf_ready(data_cnf_ready),
    .data_cnf_identifier(data_cnf_identifier), .data_cnf_status(data_cnf_status),
    .remote_cnf_valid(remote_cnf_valid), .remote_cnf_ready(remote_cnf_ready),
    .remote_cnf_identifier(remote_cnf_identifier), .remote_cnf_status(remote_cnf_status),
    .ovld_cnf_valid(ovld_cnf_valid), .ovld_cnf_ready(ovld_cnf_ready),
    .ovld_cnf_status(ovld_cnf_status)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    data_req_valid = 1'b0; data_req_identifier = '0; data_req_dlc = '0; data_req_data_payload = '0;
    remote_req_valid = 1'b0; remote_req_identifier = '0; remote_req_dlc = '0;
    ovld_req_valid = 1'b0; tx_ready = 1'b0; tx_done = 1'b0; tx_success = 1'b0;
    data_cnf_ready = 1'b0; remote_cnf_ready = 1'b0; ovld_cnf_ready = 1'b0;
  endtask

  function automatic logic [112:0] all_outputs();
    return {tx_valid, tx_frame_type, tx_identifier, tx_dlc, tx_data,
            data_cnf_valid, data_cnf_identifier, data_cnf_status,
            remote_cnf_valid, remote_cnf_identifier, remote_cnf_status,
            ovld_cnf_valid, ovld_cnf_status,
            data_req_ready, remote_req_ready, ovld_req_ready};
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (data_req_ready || remote_req_ready || ovld_req_ready) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  // Presents a set of simultaneous requests and plays transmitter and LLC until
  // all are confirmed. mask bit a = outcome of attempt a (1 = success).
  task automatic run_batch(input bit dv, input bit rv, input bit ov,
                           input logic [10:0] did, input logic [10:0] rid,
                           input logic [3:0] ddlc, input logic [3:0] rdlc,
                           input logic [63:0] dpay,
                           input logic [7:0] md, input logic [7:0] mr, input logic [7:0] mo,
                           input int hold_cycles);
    logic [1:0]  q_type [3];
    logic [10:0] q_id   [3];
    logic [3:0]  q_dlc  [3];
    logic [63:0] q_data [3];
    logic [7:0]  q_mask [3];
    int          q_key  [3];
    int          n = 0;
    bit          ok;
    // Reference model: overload first, then CAN priority (id, data before remote).
    if (ov) begin q_type[n] = 2'b10; q_id[n] = '0;  q_dlc[n] = '0;   q_data[n] = '0;   q_mask[n] = mo; q_key[n] = 0;              n++; end
    if (dv) begin q_type[n] = 2'b00; q_id[n] = did; q_dlc[n] = ddlc; q_data[n] = dpay; q_mask[n] = md; q_key[n] = 2*int'(did) + 1; n++; end
    if (rv) begin q_type[n] = 2'b01; q_id[n] = rid; q_dlc[n] = rdlc; q_data[n] = '0;   q_mask[n] = mr; q_key[n] = 2*int'(rid) + 2; n++; end
    for (int i = 0; i < n; i++)
      for (int j = 0; j + 1 < n - i; j++)
        if (q_key[j] > q_key[j+1]) begin
          {q_type[j], q_type[j+1]} = {q_type[j+1], q_type[j]};
          {q_id[j], q_id[j+1]}     = {q_id[j+1], q_id[j]};
          {q_dlc[j], q_dlc[j+1]}   = {q_dlc[j+1], q_dlc[j]};
          {q_data[j], q_data[j+1]} = {q_data[j+1], q_data[j]};
          {q_mask[j], q_mask[j+1]} = {q_mask[j+1], q_mask[j]};
          {q_key[j], q_key[j+1]}   = {q_key[j+1], q_key[j]};
        end

    data_req_identifier = did; data_req_dlc = ddlc; data_req_data_payload = dpay;
    remote_req_identifier = rid; remote_req_dlc = rdlc;
    data_req_valid = dv; remote_req_valid = rv; ovld_req_valid = ov;

    for (int f = 0; f < n; f++) begin
      logic [2:0] exp_rdy;
      int         exp_att, exp_st, handshakes, hold, d, idle;
      exp_rdy = (q_type[f] == 2'b00) ? 3'b100 : (q_type[f] == 2'b01) ? 3'b010 : 3'b001;
      exp_att = MAXR + 1;
      exp_st  = 1;
      for (int a = 0; a <= MAXR; a++)
        if (q_mask[f][a]) begin exp_att = a + 1; exp_st = 0; break; end

      wait_req(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL grant_timeout frame %0d: no req_ready seen, expected ready=%b", f, exp_rdy);
        clear_inputs();
        return;
      end
      n_cmp++;
      if ({data_req_ready, remote_req_ready, ovld_req_ready} !== exp_rdy) begin
        n_bad++;
        $display("FAIL grant frame %0d: ready {d,r,o}=%b expected %b", f, {data_req_ready, remote_req_ready, ovld_req_ready}, exp_rdy);
      end
      cyc();
      if (exp_rdy[2]) data_req_valid = 1'b0;
      if (exp_rdy[1]) remote_req_valid = 1'b0;
      if (exp_rdy[0]) ovld_req_valid = 1'b0;

      handshakes = 0;
      for (int a = 0; a <= MAXR; a++) begin
        n_cmp++;
        if ({tx_valid, tx_frame_type, tx_identifier, tx_dlc, tx_data} !== {1'b1, q_type[f], q_id[f], q_dlc[f], q_data[f]}) begin
          n_bad++;
          $display("FAIL tx_issue frame %0d attempt %0d: got v=%b t=%b id=%h dlc=%h data=%h expected v=1 t=%b id=%h dlc=%h data=%h",
                   f, a, tx_valid, tx_frame_type, tx_identifier, tx_dlc, tx_data, q_type[f], q_id[f], q_dlc[f], q_data[f]);
        end
        d = $urandom_range(0, 2);
        for (int w = 0; w < d; w++) begin
          tx_done = (w == 0);
          tx_success = 1'b1;
          cyc();
          tx_done = 1'b0;
          tx_success = 1'b0;
          n_cmp++;
          if (tx_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_hold frame %0d: tx_valid=%b expected 1 while tx_ready low", f, tx_valid);
          end
        end
        tx_ready = 1'b1;
        #1;
        if (tx_valid === 1'b1) handshakes++;
        cyc();
        tx_ready = 1'b0;
        n_cmp++;
        if ({tx_valid, data_cnf_valid, remote_cnf_valid, ovld_cnf_valid} !== 4'b0000) begin
          n_bad++;
          $display("FAIL wait_done frame %0d: tx_valid/cnf_valids=%b expected 0000", f, {tx_valid, data_cnf_valid, remote_cnf_valid, ovld_cnf_valid});
        end
        idle = $urandom_range(0, 3);
        for (int w = 0; w < idle; w++) cyc();
        tx_done = 1'b1;
        tx_success = q_mask[f][a];
        cyc();
        tx_done = 1'b0;
        tx_success = 1'b0;
        if (q_mask[f][a]) break;
      end
      n_cmp++;
      if (handshakes !== exp_att) begin
        n_bad++;
        $display("FAIL attempts frame %0d: %0d tx handshakes expected %0d", f, handshakes, exp_att);
      end

      hold = (hold_cycles < 0) ? int'($urandom_range(0, 3)) : hold_cycles;
      data_cnf_ready   = !exp_rdy[2];
      remote_cnf_ready = !exp_rdy[1];
      ovld_cnf_ready   = !exp_rdy[0];
      for (int h = 0; h <= hold; h++) begin
        logic [11:0] got_f;
        got_f = exp_rdy[2] ? {data_cnf_identifier, data_cnf_status} :
                exp_rdy[1] ? {remote_cnf_identifier, remote_cnf_status} : {11'h000, ovld_cnf_status};
        n_cmp++;
        if ({data_cnf_valid, remote_cnf_valid, ovld_cnf_valid, tx_valid, data_req_ready, remote_req_ready, ovld_req_ready, got_f}
            !== {exp_rdy, 1'b0, 3'b000, q_id[f], exp_st[0]}) begin
          n_bad++;
          $display("FAIL confirm frame %0d cycle %0d: cnf_v=%b tx_v=%b req_rdy=%b id/st=%h expected cnf_v=%b tx_v=0 req_rdy=000 id/st=%h",
                   f, h, {data_cnf_valid, remote_cnf_valid, ovld_cnf_valid}, tx_valid,
                   {data_req_ready, remote_req_ready, ovld_req_ready}, got_f, exp_rdy, {q_id[f], exp_st[0]});
        end
        if (h < hold) cyc();
      end
      data_cnf_ready = exp_rdy[2];
      remote_cnf_ready = exp_rdy[1];
      ovld_cnf_ready = exp_rdy[0];
      cyc();
      data_cnf_ready = 1'b0;
      remote_cnf_ready = 1'b0;
      ovld_cnf_ready = 1'b0;
      #1;
      begin
        logic [2:0] nxt;
        nxt = 3'b000;
        if (f + 1 < n) nxt = (q_type[f+1] == 2'b00) ? 3'b100 : (q_type[f+1] == 2'b01) ? 3'b010 : 3'b001;
        n_cmp++;
        if ({data_cnf_valid, remote_cnf_valid, ovld_cnf_valid, tx_valid, data_req_ready, remote_req_ready, ovld_req_ready}
            !== {4'b0000, nxt}) begin
          n_bad++;
          $display("FAIL idle_after_cnf frame %0d: cnf_v/tx_v=%b req_rdy=%b expected 0000 / %b", f,
                   {data_cnf_valid, remote_cnf_valid, ovld_cnf_valid, tx_valid},
                   {data_req_ready, remote_req_ready, ovld_req_ready}, nxt);
        end
      end
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    data_req_valid = 1'b1;
    data_req_identifier = 11'h321;
    ovld_req_valid = 1'b1;
    reset_n = 1'b0;
    #3;
    n_cmp++;
    if (all_outputs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: outputs=%h expected 0", all_outputs());
    end
    cyc();
    cyc();
    clear_inputs();
    reset_n = 1'b1;
    cyc();
    n_cmp++;
    if (all_outputs() !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle: outputs=%h expected 0", all_outputs());
    end
  endtask

  task automatic test_single_data();
    run_batch(1, 0, 0, 11'h123, 11'h000, 4'd8, 4'd0, 64'h0011223344556677, 8'h01, 8'h00, 8'h00, 0);
  endtask

  task automatic test_priority();
    run_batch(1, 1, 0, 11'h200, 11'h100, 4'd2, 4'd3, 64'hDEADBEEF_CAFEF00D, 8'h01, 8'h01, 8'h00, -1);
  endtask

  task automatic test_same_id();
    run_batch(1, 1, 0, 11'h0AA, 11'h0AA, 4'd1, 4'd5, 64'h1, 8'h02, 8'h04, 8'h00, -1);
  endtask

  task automatic test_overload();
    run_batch(1, 0, 1, 11'h000, 11'h000, 4'd4, 4'd0, 64'hA5A5_5A5A_0F0F_F0F0, 8'h01, 8'h00, 8'h01, -1);
  endtask

  task automatic test_retry_exhaust();
    run_batch(1, 0, 0, 11'h7FF, 11'h000, 4'd15, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 8'h00, -1);
    run_batch(0, 0, 1, 11'h000, 11'h000, 4'd0, 4'd0, 64'h0, 8'h00, 8'h00, 8'h08, -1);
  endtask

  task automatic test_confirm_stall();
    run_batch(1, 1, 0, 11'h010, 11'h020, 4'd6, 4'd7, 64'h0123_4567_89AB_CDEF, 8'h01, 8'h01, 8'h00, 10);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int stray;
    clear_inputs();
    data_req_identifier = 11'h055;
    data_req_dlc = 4'd2;
    data_req_data_payload = 64'h0000_0000_0000_BEEF;
    data_req_valid = 1'b1;
    wait_req(ok);
    n_cmp++;
    if (!ok || data_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_grant: data_req_ready=%b expected 1", data_req_ready);
    end
    cyc();
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_wait: tx_valid=%b expected 0 in WAIT_DONE", tx_valid);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outputs() !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: outputs=%h expected 0", all_outputs());
    end
    cyc();
    cyc();
    data_req_valid = 1'b0;
    reset_n = 1'b1;
    tx_done = 1'b1;
    tx_success = 1'b1;
    cyc();
    tx_done = 1'b0;
    tx_success = 1'b0;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      if ({tx_valid, data_cnf_valid, remote_cnf_valid, ovld_cnf_valid} !== 4'b0000) stray++;
      cyc();
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL rst_mid_stale: %0d cycles with tx_valid/cnf_valid after reset, expected 0", stray);
    end
    run_batch(1, 0, 0, 11'h055, 11'h000, 4'd2, 4'd0, 64'h0000_0000_0000_BEEF, 8'h01, 8'h00, 8'h00, -1);
  endtask

  task automatic test_random();
    for (int b = 0; b < 40; b++) begin
      bit dv, rv, ov;
      logic [10:0] did, rid;
      dv = 1'($urandom);
      rv = 1'($urandom);
      ov = 1'($urandom_range(0, 3) == 0);
      if (!dv && !rv && !ov) dv = 1'b1;
      did = 11'($urandom);
      rid = ($urandom_range(0, 3) == 0) ? did : 11'($urandom);
      run_batch(dv, rv, ov, did, rid, 4'($urandom), 4'($urandom), {$urandom, $urandom},
                8'($urandom), 8'($urandom), 8'($urandom), -1);
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_data();
    test_priority();
    test_same_id();
    test_overload();
    test_retry_exhaust();
    test_confirm_stall();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
